// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg -- shared definitions for the data-memory controller slice.
//   * rv32i memory-mode codes (access width) and their field width
//   * controller FSM state type
//   * default DMEM parameters (depth in words, extra stall cycles)
package dmem_ctrl_pkg;

    localparam int unsigned MEMORY_MODE_WIDTH = 2;

    typedef enum logic [MEMORY_MODE_WIDTH-1:0] {
        MEM_NOP      = 2'd0,
        MEM_BYTE     = 2'd1,
        MEM_HALFWORD = 2'd2,
        MEM_WORD     = 2'd3
    } mem_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } dmem_state_e;

    localparam int unsigned DMEM_DEPTH_WORDS_DEFAULT = 1024;
    localparam int unsigned DMEM_WAIT_CYCLES_DEFAULT = 1;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align -- combinational byte-lane steering for dmem_ctrl.
// Store side: byte enables and lane-replicated write data.
// Load side: lane extract plus sign/zero extension.
// Optional macro DMEM_MISALIGN_CHECK_EN: when defined, misaligned HALFWORD/WORD
// accesses raise 'misaligned'; otherwise low address bits are forced aligned.
// Ports:
//   mode        access width (mem_mode_e code)
//   is_unsigned zero-extend loads when 1, sign-extend when 0
//   addr_lo     byte offset within the word (addr[1:0])
//   store_data  right-aligned store data
//   mem_word    current contents of the addressed word
//   byte_en     per-lane write enable
//   store_word  store data replicated onto the selected lanes
//   load_data   extracted and extended load result
//   misaligned  access violates natural alignment (0 when check disabled)
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [MEMORY_MODE_WIDTH-1:0] mode,
    input  logic                         is_unsigned,
    input  logic [1:0]                   addr_lo,
    input  logic [31:0]                  store_data,
    input  logic [31:0]                  mem_word,
    output logic [3:0]                   byte_en,
    output logic [31:0]                  store_word,
    output logic [31:0]                  load_data,
    output logic                         misaligned
);

    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        off        = addr_lo;
        misaligned = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        misaligned = ((mode == MEM_HALFWORD) && addr_lo[0]) ||
                     ((mode == MEM_WORD) && (addr_lo != 2'b00));
`else
        if (mode == MEM_HALFWORD) begin
            off[0] = 1'b0;
        end else if (mode == MEM_WORD) begin
            off = 2'b00;
        end
`endif
    end

    // Bring the addressed lane down to bit 0 before extraction.
    assign shifted = mem_word >> {off, 3'b000};

    always_comb begin
        byte_en    = 4'b0000;
        store_word = '0;
        load_data  = '0;
        case (mode)
            MEM_BYTE: begin
                byte_en    = 4'b0001 << off;
                store_word = {4{store_data[7:0]}};
                load_data  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALFWORD: begin
                byte_en    = 4'b0011 << {off[1], 1'b0};
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = mem_word;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = '0;
                load_data  = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- multi-cycle data-memory controller with byte/half/word access.
// A request is captured in IDLE, stalls WAIT_CYCLES cycles in WAIT, commits
// (store) or samples (load) on the RESP edge, and D_MEM_valid pulses during
// the following IDLE cycle. Addresses wrap modulo DEPTH_WORDS*4 bytes.
// Optional macro DMEM_MISALIGN_CHECK_EN: flag misaligned accesses instead of
// force-aligning them.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   D_MEM_read/write  load / store request (write wins if both)
//   D_MEM_mode        access width code (NOP requests are ignored)
//   D_MEM_unsigned    zero-extend loads when 1
//   D_MEM_addr        byte address
//   D_MEM_dataIn      right-aligned store data
//   D_MEM_dataOut     registered load result, held until the next load
//   D_MEM_busy        high whenever the FSM is not IDLE
//   D_MEM_valid       one-cycle completion pulse
//   D_MEM_misaligned  error flag qualified by D_MEM_valid
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         D_MEM_read,
    input  logic                         D_MEM_write,
    input  logic [MEMORY_MODE_WIDTH-1:0] D_MEM_mode,
    input  logic                         D_MEM_unsigned,
    input  logic [31:0]                  D_MEM_addr,
    input  logic [31:0]                  D_MEM_dataIn,
    output logic [31:0]                  D_MEM_dataOut,
    output logic                         D_MEM_busy,
    output logic                         D_MEM_valid,
    output logic                         D_MEM_misaligned
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    dmem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept;

    logic                         cap_write;
    logic [MEMORY_MODE_WIDTH-1:0] cap_mode;
    logic                         cap_unsigned;
    logic [IDX_W+1:0]             cap_addr;
    logic [31:0]                  cap_data;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] mem_word;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_mis;
    logic        in_resp;
    logic        do_store;
    logic        do_load;

    logic [31:0] dout_q;
    logic        valid_q;

    // Address bits above the memory size are deliberately ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^D_MEM_addr[31:IDX_W+2];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((D_MEM_read || D_MEM_write) && (D_MEM_mode != MEM_NOP)) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_write    <= 1'b0;
            cap_mode     <= '0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_data     <= '0;
        end else if (accept) begin
            // Write has priority: a simultaneous read is simply dropped.
            cap_write    <= D_MEM_write;
            cap_mode     <= D_MEM_mode;
            cap_unsigned <= D_MEM_unsigned;
            cap_addr     <= D_MEM_addr[IDX_W+1:0];
            cap_data     <= D_MEM_dataIn;
        end
    end

    // ---------------- lane steering ----------------
    assign mem_word = mem[cap_addr[IDX_W+1:2]];

    dmem_lane_align u_lane_align (
        .mode        (cap_mode),
        .is_unsigned (cap_unsigned),
        .addr_lo     (cap_addr[1:0]),
        .store_data  (cap_data),
        .mem_word    (mem_word),
        .byte_en     (lane_be),
        .store_word  (lane_wdata),
        .load_data   (lane_rdata),
        .misaligned  (lane_mis)
    );

    assign in_resp  = (state_q == S_RESP);
    assign do_store = in_resp &  cap_write & ~lane_mis;
    assign do_load  = in_resp & ~cap_write & ~lane_mis;

    // Storage is intentionally not reset. A reset during WAIT returns the FSM
    // to IDLE asynchronously, so the RESP edge that would commit never occurs.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem[cap_addr[IDX_W+1:2]][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_resp;
            if (do_load) begin
                dout_q <= lane_rdata;
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= in_resp & lane_mis;
        end
    end
    assign D_MEM_misaligned = mis_q;
`else
    assign D_MEM_misaligned = 1'b0;
`endif

    assign D_MEM_dataOut = dout_q;
    assign D_MEM_valid   = valid_q;
    assign D_MEM_busy    = (state_q != S_IDLE);

endmodule
